// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Receive-side checker for a looped-back VGA sync/RGB stream. Every input is
//   sampled only on CLK edges where PIX_STB=1. The block measures the line
//   period, the HS width and the frame length, and it locks after LOCK_FRAMES
//   consecutive good frames. It counts frames and timing errors, and it
//   captures the RGB value at one programmable active-area coordinate.
//
//   Ports
//     CLK, RST_BTN          clock, asynchronous active-low reset
//     PIX_STB               pixel strobe that qualifies all sampling
//     VGA_HS_I, VGA_VS_I    active-low syncs
//     VGA_RGB_I             {R,G,B} 4 bits each
//     CAP_X, CAP_Y          capture coordinate, latched at each VS fall
//     LOCKED                timing locked (registered from the state)
//     H_PERIOD, HS_WIDTH    last line period / HS low width, pixel clocks
//     V_PERIOD              last frame length, lines
//     FRAME_CNT             frames evaluated since reset (wraps)
//     ERR_CNT               timing errors (saturates)
//     CAP_RGB, CAP_VALID    captured pixel and its 1-CLK update pulse
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 3
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        PIX_STB,
    input  logic        VGA_HS_I,
    input  logic        VGA_VS_I,
    input  logic [11:0] VGA_RGB_I,
    input  logic [9:0]  CAP_X,
    input  logic [9:0]  CAP_Y,
    output logic        LOCKED,
    output logic [11:0] H_PERIOD,
    output logic [11:0] HS_WIDTH,
    output logic [10:0] V_PERIOD,
    output logic [15:0] FRAME_CNT,
    output logic [7:0]  ERR_CNT,
    output logic [11:0] CAP_RGB,
    output logic        CAP_VALID
);

    typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} state_t;

    localparam logic [11:0] H_TOT   = 12'(H_TOTAL);
    localparam logic [11:0] H_SYN   = 12'(H_SYNC);
    localparam logic [11:0] H_LIMIT = 12'(2 * H_TOTAL);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
    localparam logic [10:0] V_SYN   = 11'(V_SYNC);
    localparam logic [10:0] V_LIMIT = 11'(2 * V_TOTAL);

    state_t      state, state_nxt;
    logic [7:0]  good_cnt, good_nxt;
    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    logic [10:0] vs_width;
    logic        hs_prev, vs_prev;
    logic        h_seen;
    logic        line_err;
    logic [9:0]  cx, cy;

    logic        hs_fall, hs_rise, vs_fall;
    logic [11:0] h_inc, h_cur;
    logic [10:0] v_inc, v_cur;
    logic        timeout, frame_eval, frame_bad, line_err_now, cap_hit;
    logic        frame_inc, err_inc;

    // Edges are found against the previous sampled value, so all of them
    // are qualified by the strobe.
    assign hs_fall = PIX_STB &  hs_prev & ~VGA_HS_I;
    assign hs_rise = PIX_STB & ~hs_prev &  VGA_HS_I;
    assign vs_fall = PIX_STB &  vs_prev & ~VGA_VS_I;

    // h_cur and v_cur are the coordinates of the pixel now on the inputs.
    assign h_inc = h_cnt + 12'd1;
    assign h_cur = hs_fall ? 12'd0 : h_inc;
    assign v_inc = v_cnt + 11'd1;
    assign v_cur = vs_fall ? 11'd0 : (hs_fall ? v_inc : v_cnt);

    // A counter that reaches twice its nominal span means the stream is gone.
    // Timeout has priority over any VS evaluation on the same strobe.
    assign timeout = (PIX_STB & ~hs_fall & (h_inc == H_LIMIT)) |
                     (hs_fall & (v_inc == V_LIMIT));

    // The line that closes on this strobe is included, so a VS fall that
    // coincides with an HS fall also sees the last line's result.
    assign line_err_now = line_err |
                          (hs_fall & h_seen & (h_inc != H_TOT)) |
                          (hs_rise & (h_inc != H_SYN));
    assign frame_bad  = (v_inc != V_TOT) | (vs_width != V_SYN) | line_err_now;
    assign frame_eval = vs_fall & ~timeout;

    assign cap_hit = PIX_STB &
                     ({1'b0, cx} < 11'(H_ACTIVE)) &
                     ({1'b0, cy} < 11'(V_ACTIVE)) &
                     (h_cur == 12'(H_ACT_START) + {2'b00, cx}) &
                     (v_cur == 11'(V_ACT_START) + {1'b0, cy});

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        if (timeout) begin
            state_nxt = ST_SEARCH;
            err_inc   = 1'b1;
        end else if (frame_eval) begin
            case (state)
                ST_SEARCH: begin
                    state_nxt = ST_TRACK;
                    good_nxt  = 8'd0;
                end
                ST_TRACK: begin
                    frame_inc = 1'b1;
                    if (frame_bad) begin
                        err_inc  = 1'b1;
                        good_nxt = 8'd0;
                    end else begin
                        good_nxt = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == 8'(LOCK_FRAMES))
                            state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    frame_inc = 1'b1;
                    if (frame_bad) begin
                        err_inc   = 1'b1;
                        good_nxt  = 8'd0;
                        state_nxt = ST_TRACK;
                    end
                end
                default: state_nxt = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state     <= ST_SEARCH;
            good_cnt  <= 8'd0;
            LOCKED    <= 1'b0;
            FRAME_CNT <= 16'd0;
            ERR_CNT   <= 8'd0;
            CAP_VALID <= 1'b0;
            CAP_RGB   <= 12'd0;
            H_PERIOD  <= 12'd0;
            HS_WIDTH  <= 12'd0;
            V_PERIOD  <= 11'd0;
            h_cnt     <= 12'd0;
            v_cnt     <= 11'd0;
            vs_width  <= 11'd0;
            hs_prev   <= 1'b1;
            vs_prev   <= 1'b1;
            h_seen    <= 1'b0;
            line_err  <= 1'b0;
            cx        <= 10'd0;
            cy        <= 10'd0;
        end else begin
            state     <= state_nxt;
            good_cnt  <= good_nxt;
            // One CLK behind the state register.
            LOCKED    <= (state == ST_LOCKED);
            CAP_VALID <= cap_hit;
            if (frame_inc)
                FRAME_CNT <= FRAME_CNT + 16'd1;
            if (err_inc && ERR_CNT != 8'hFF)
                ERR_CNT <= ERR_CNT + 8'd1;
            if (PIX_STB) begin
                hs_prev <= VGA_HS_I;
                vs_prev <= VGA_VS_I;
                if (cap_hit)
                    CAP_RGB <= VGA_RGB_I;
                if (hs_fall && h_seen)
                    H_PERIOD <= h_inc;
                if (hs_rise)
                    HS_WIDTH <= h_inc;
                if (vs_fall) begin
                    cx <= CAP_X;
                    cy <= CAP_Y;
                end
                if (timeout) begin
                    h_cnt    <= 12'd0;
                    v_cnt    <= 11'd0;
                    vs_width <= 11'd0;
                    line_err <= 1'b0;
                    h_seen   <= 1'b0;
                end else begin
                    h_cnt <= h_cur;
                    v_cnt <= v_cur;
                    if (hs_fall)
                        h_seen <= 1'b1;
                    if (vs_fall) begin
                        V_PERIOD <= v_inc;
                        // The HS fall on the VS-fall strobe is the first
                        // line of the new sync pulse.
                        vs_width <= {10'd0, hs_fall};
                        line_err <= 1'b0;
                    end else begin
                        line_err <= line_err_now;
                        if (hs_fall && !VGA_VS_I)
                            vs_width <= vs_width + 11'd1;
                    end
                end
            end
        end
    end

endmodule
